// File: rtl/qsys_system_chaos_code_start_if.sv
// Avalon-MM register bus between the Nios II data master and the chaos-code launcher.
// The master drives address/strobes/data; the slave returns registered readdata.
interface qsys_system_chaos_code_start_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/qsys_system_chaos_code_start.sv
// Launches one chaos-code operation: fixed-width start pulse, then waits for the core's
// done rising edge or a programmable timeout, and reports the outcome through a maskable irq.
module qsys_system_chaos_code_start #(
    parameter int DATA_WIDTH    = 32,
    parameter int PULSE_CYCLES  = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    qsys_system_chaos_code_start_if.slave  bus,
    output logic                           start_out,
    output logic [DATA_WIDTH-1:0]          data_out,
    input  logic                           done_in,
    output logic                           irq
);

    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT
    } state_t;

    state_t                   state;
    logic [PCW-1:0]           pulse_cnt;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    logic [TIMEOUT_WIDTH-1:0] limit;
    logic                     irq_en;
    logic                     done_flag;
    logic                     timeout_flag;
    logic                     done_d;

    logic                     wr;
    logic                     busy;
    logic                     done_edge;
    logic                     start_req;
    logic                     limit_hit;
    logic                     set_done;
    logic                     set_timeout;
    logic [31:0]              read_mux;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign busy        = (state != ST_IDLE);
    assign done_edge   = done_in & ~done_d;
    assign start_req   = wr && (bus.address == 2'd1) && bus.writedata[0];
    assign limit_hit   = (limit != '0) && (wait_cnt == (limit - TIMEOUT_WIDTH'(1)));
    assign set_done    = (state == ST_WAIT) && done_edge;
    assign set_timeout = (state == ST_WAIT) && !done_edge && limit_hit;
    assign irq         = irq_en & (done_flag | timeout_flag);

    // Launch sequencer; start_out is registered so it rises the cycle after the START write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pulse_cnt <= '0;
            wait_cnt  <= '0;
            start_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_PULSE;
                        pulse_cnt <= '0;
                        start_out <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= ST_WAIT;
                        wait_cnt  <= '0;
                        start_out <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PCW'(1);
                    end
                end
                ST_WAIT: begin
                    if (done_edge || limit_hit) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    start_out <= 1'b0;
                end
            endcase
        end
    end

    // CPU-visible registers; a completion set in the same cycle as a W1C clear survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out     <= '0;
            irq_en       <= 1'b0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            limit        <= '0;
            done_d       <= 1'b0;
        end else begin
            done_d <= done_in;
            if (wr && (bus.address == 2'd0) && !busy) begin
                data_out <= bus.writedata[DATA_WIDTH-1:0];
            end
            if (wr && (bus.address == 2'd1)) begin
                irq_en <= bus.writedata[1];
            end
            if (wr && (bus.address == 2'd3)) begin
                limit <= bus.writedata[TIMEOUT_WIDTH-1:0];
            end
            if (set_done) begin
                done_flag <= 1'b1;
            end else if (wr && (bus.address == 2'd2) && bus.writedata[1]) begin
                done_flag <= 1'b0;
            end
            if (set_timeout) begin
                timeout_flag <= 1'b1;
            end else if (wr && (bus.address == 2'd2) && bus.writedata[2]) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        read_mux = '0;
        case (bus.address)
            2'd0:    read_mux[DATA_WIDTH-1:0]    = data_out;
            2'd1:    read_mux[1]                 = irq_en;
            2'd2:    read_mux[2:0]               = {timeout_flag, done_flag, busy};
            default: read_mux[TIMEOUT_WIDTH-1:0] = limit;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= read_mux;
        end
    end

endmodule
